vrf_port_sched: RTL and testbench

Scheduler that shares the vector register file's single read sequencer and single write port between `NREQ` requesters, for example the vector ALU issue stage and the load/store unit. It arbitrates each channel round-robin and issues the one-cycle read/write requests the VRF expects. It also generates the per-lane element counters, routes the winner's addresses and write data, and returns per-requester handshakes. It sits directly between the requesters and the VRF.

---
 rtl/vrf_pkg.sv | 40 ++++
 rtl/vrf_port_sched_if.sv | 57 +++++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/vrf_port_sched.sv | 168 ++++++++++++++++
 tb/tb_vrf_port_sched.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vrf_pkg.sv
// Shared types and width helpers for the VRF port scheduler.
// Holds the default geometry, the bit-width derivations and the
// read/write channel state enums used by every file of this block.
package vrf_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int REG_NUM_DEF    = 32;
  localparam int LANES_DEF      = 4;
  localparam int NREQ_DEF       = 2;

  function automatic int addrBits(input int regNum);
    return $clog2(regNum);
  endfunction

  function automatic int elemBits(input int lanes);
    return $clog2(lanes);
  endfunction

  function automatic int idxBits(input int nreq);
    return $clog2(nreq);
  endfunction

  localparam int ADDR_B_DEF = addrBits(REG_NUM_DEF);
  localparam int ELEM_B_DEF = elemBits(LANES_DEF);
  localparam int IDX_B_DEF  = idxBits(NREQ_DEF);

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_WAIT,
    R_STREAM
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_DATA
  } wr_state_t;

endpackage

// File: rtl/vrf_port_sched_if.sv
// Bundle of every requester-side and VRF-side signal of the scheduler.
// The slave modport is the scheduler's view; the master modport is the
// view of whoever drives the requesters and models the VRF.
interface vrf_port_sched_if #(
  parameter int DATA_WIDTH = vrf_pkg::DATA_WIDTH_DEF,
  parameter int REG_NUM    = vrf_pkg::REG_NUM_DEF,
  parameter int LANES      = vrf_pkg::LANES_DEF,
  parameter int NREQ       = vrf_pkg::NREQ_DEF
);
  localparam int ADDR_B = vrf_pkg::addrBits(REG_NUM);
  localparam int ELEM_B = vrf_pkg::elemBits(LANES);

  logic [NREQ-1:0]            rd_valid_i;
  logic [NREQ*ADDR_B-1:0]     rd_a_addr_i;
  logic [NREQ*ADDR_B-1:0]     rd_b_addr_i;
  logic [NREQ*ADDR_B-1:0]     rd_c_addr_i;
  logic [NREQ-1:0]            rd_use_c_i;
  logic [NREQ-1:0]            rd_done_o;
  logic [NREQ-1:0]            rd_elem_valid_o;
  logic [NREQ-1:0]            wr_valid_i;
  logic [NREQ*ADDR_B-1:0]     wr_addr_i;
  logic [NREQ*DATA_WIDTH-1:0] wdata_i;
  logic [NREQ-1:0]            wr_ack_o;
  logic [NREQ-1:0]            wr_done_o;
  logic                       vrf_rd_req_o;
  logic                       vrf_is_c_used_o;
  logic [ADDR_B-1:0]          vrf_a_addr_o;
  logic [ADDR_B-1:0]          vrf_b_addr_o;
  logic [ADDR_B-1:0]          vrf_c_addr_o;
  logic                       vrf_rd_op_ready_i;
  logic [ELEM_B-1:0]          vrf_rd_elem_cnt_o;
  logic                       vrf_wr_req_o;
  logic                       vrf_wr_en_o;
  logic                       vrf_wr_ready_o;
  logic [ADDR_B-1:0]          vrf_wr_addr_o;
  logic [ELEM_B-1:0]          vrf_wr_elem_cnt_o;
  logic [DATA_WIDTH-1:0]      vrf_wdata_o;

  modport slave (
    input  rd_valid_i, rd_a_addr_i, rd_b_addr_i, rd_c_addr_i, rd_use_c_i,
    input  wr_valid_i, wr_addr_i, wdata_i, vrf_rd_op_ready_i,
    output rd_done_o, rd_elem_valid_o, wr_ack_o, wr_done_o,
    output vrf_rd_req_o, vrf_is_c_used_o, vrf_a_addr_o, vrf_b_addr_o, vrf_c_addr_o,
    output vrf_rd_elem_cnt_o, vrf_wr_req_o, vrf_wr_en_o, vrf_wr_ready_o,
    output vrf_wr_addr_o, vrf_wr_elem_cnt_o, vrf_wdata_o
  );

  modport master (
    output rd_valid_i, rd_a_addr_i, rd_b_addr_i, rd_c_addr_i, rd_use_c_i,
    output wr_valid_i, wr_addr_i, wdata_i, vrf_rd_op_ready_i,
    input  rd_done_o, rd_elem_valid_o, wr_ack_o, wr_done_o,
    input  vrf_rd_req_o, vrf_is_c_used_o, vrf_a_addr_o, vrf_b_addr_o, vrf_c_addr_o,
    input  vrf_rd_elem_cnt_o, vrf_wr_req_o, vrf_wr_en_o, vrf_wr_ready_o,
    input  vrf_wr_addr_o, vrf_wr_elem_cnt_o, vrf_wdata_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the requester just granted drops to lowest priority.
// The pointer names the highest-priority requester and only moves on advance,
// so a skipped (non-requesting) index never loses its place.
module rr_arbiter
  import vrf_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic                     adv_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [idxBits(NREQ)-1:0] idx_o
);
  localparam int IDX_B = idxBits(NREQ);

  logic [IDX_B-1:0] ptr_q;

  // Two descending passes so the final write is the lowest index at or above
  // the pointer, falling back to the lowest index below it.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i] && (i < int'(ptr_q))) begin
        gnt_o = NREQ'(1) << i;
        idx_o = IDX_B'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i] && (i >= int'(ptr_q))) begin
        gnt_o = NREQ'(1) << i;
        idx_o = IDX_B'(i);
      end
    end
  end

  // Pointer moves to the requester just after the one granted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (adv_i) begin
      ptr_q <= (idx_o == IDX_B'(NREQ - 1)) ? '0 : idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/vrf_port_sched.sv
// Shares the VRF read sequencer and write port between NREQ requesters.
// Read and write channels each own a round-robin arbiter and an FSM.
// Optional feature macro: VRF_SCHED_RAW_CHECK_EN blocks a read grant for a
// requester whose source addresses hit the register being written.
module vrf_port_sched
  import vrf_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int REG_NUM    = REG_NUM_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int NREQ       = NREQ_DEF
) (
  input logic             clk_i,
  input logic             rst_i,
  vrf_port_sched_if.slave bus
);
  localparam int ADDR_B = addrBits(REG_NUM);
  localparam int ELEM_B = elemBits(LANES);
  localparam int IDX_B  = idxBits(NREQ);
  localparam logic [ELEM_B-1:0] LAST_ELEM = ELEM_B'(LANES - 1);

  rd_state_t         rdState_q;
  logic [IDX_B-1:0]  rdWin_q;
  logic [ADDR_B-1:0] rdA_q, rdB_q, rdC_q;
  logic              rdUseC_q;
  logic [ELEM_B-1:0] rdCnt_q;
  logic [NREQ-1:0]   rdElig, rdGnt;
  logic [IDX_B-1:0]  rdIdx;
  logic              rdAdv;

  wr_state_t         wrState_q;
  logic [IDX_B-1:0]  wrWin_q;
  logic [ADDR_B-1:0] wrAddr_q;
  logic [ELEM_B-1:0] wrCnt_q;
  logic [NREQ-1:0]   wrGnt;
  logic [IDX_B-1:0]  wrIdx;
  logic              wrAdv, wrAccept, wrLast;

  // Read eligibility: optionally mask requesters that would read a register
  // still being written by the active write burst.
  always_comb begin
    rdElig = bus.rd_valid_i;
`ifdef VRF_SCHED_RAW_CHECK_EN
    for (int i = 0; i < NREQ; i++) begin
      if ((wrState_q != W_IDLE) &&
          ((bus.rd_a_addr_i[i*ADDR_B +: ADDR_B] == wrAddr_q) ||
           (bus.rd_b_addr_i[i*ADDR_B +: ADDR_B] == wrAddr_q) ||
           (bus.rd_use_c_i[i] && (bus.rd_c_addr_i[i*ADDR_B +: ADDR_B] == wrAddr_q)))) begin
        rdElig[i] = 1'b0;
      end
    end
`endif
  end

  assign rdAdv = (rdState_q == R_IDLE) && (|rdGnt);
  assign wrAdv = (wrState_q == W_IDLE) && (|wrGnt);

  rr_arbiter #(.NREQ(NREQ)) u_rd_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (rdElig),
    .adv_i (rdAdv),
    .gnt_o (rdGnt),
    .idx_o (rdIdx)
  );

  rr_arbiter #(.NREQ(NREQ)) u_wr_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (bus.wr_valid_i),
    .adv_i (wrAdv),
    .gnt_o (wrGnt),
    .idx_o (wrIdx)
  );

  // Read FSM: latch winner, one-cycle request, wait for the VRF, stream LANES elements.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdState_q <= R_IDLE;
      rdWin_q   <= '0;
      rdA_q     <= '0;
      rdB_q     <= '0;
      rdC_q     <= '0;
      rdUseC_q  <= 1'b0;
      rdCnt_q   <= '0;
    end else begin
      case (rdState_q)
        R_IDLE: begin
          if (rdAdv) begin
            rdWin_q   <= rdIdx;
            rdA_q     <= bus.rd_a_addr_i[int'(rdIdx)*ADDR_B +: ADDR_B];
            rdB_q     <= bus.rd_b_addr_i[int'(rdIdx)*ADDR_B +: ADDR_B];
            rdC_q     <= bus.rd_c_addr_i[int'(rdIdx)*ADDR_B +: ADDR_B];
            rdUseC_q  <= bus.rd_use_c_i[rdIdx];
            rdState_q <= R_REQ;
          end
        end
        R_REQ:  rdState_q <= R_WAIT;
        R_WAIT: begin
          if (bus.vrf_rd_op_ready_i) rdState_q <= R_STREAM;
        end
        R_STREAM: begin
          if (rdCnt_q == LAST_ELEM) begin
            rdCnt_q   <= '0;
            rdState_q <= R_IDLE;
          end else begin
            rdCnt_q <= rdCnt_q + 1'b1;
          end
        end
        default: rdState_q <= R_IDLE;
      endcase
    end
  end

  assign wrAccept = (wrState_q == W_DATA) && bus.wr_valid_i[wrWin_q];
  assign wrLast   = wrAccept && (wrCnt_q == LAST_ELEM);

  // Write FSM: latch winner, one-cycle request, then accept LANES elements with stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrState_q <= W_IDLE;
      wrWin_q   <= '0;
      wrAddr_q  <= '0;
      wrCnt_q   <= '0;
    end else begin
      case (wrState_q)
        W_IDLE: begin
          if (wrAdv) begin
            wrWin_q   <= wrIdx;
            wrAddr_q  <= bus.wr_addr_i[int'(wrIdx)*ADDR_B +: ADDR_B];
            wrState_q <= W_REQ;
          end
        end
        W_REQ:  wrState_q <= W_DATA;
        W_DATA: begin
          if (wrLast) begin
            wrCnt_q   <= '0;
            wrState_q <= W_IDLE;
          end else if (wrAccept) begin
            wrCnt_q <= wrCnt_q + 1'b1;
          end
        end
        default: wrState_q <= W_IDLE;
      endcase
    end
  end

  assign bus.vrf_rd_req_o      = (rdState_q == R_REQ);
  assign bus.vrf_is_c_used_o   = rdUseC_q;
  assign bus.vrf_a_addr_o      = rdA_q;
  assign bus.vrf_b_addr_o      = rdB_q;
  assign bus.vrf_c_addr_o      = rdC_q;
  assign bus.vrf_rd_elem_cnt_o = rdCnt_q;
  assign bus.rd_done_o         = ((rdState_q == R_WAIT) && bus.vrf_rd_op_ready_i) ?
                                 (NREQ'(1) << rdWin_q) : '0;
  assign bus.rd_elem_valid_o   = (rdState_q == R_STREAM) ? (NREQ'(1) << rdWin_q) : '0;

  assign bus.vrf_wr_req_o      = (wrState_q == W_REQ);
  assign bus.vrf_wr_en_o       = wrAccept;
  assign bus.vrf_wr_ready_o    = wrLast;
  assign bus.vrf_wr_addr_o     = wrAddr_q;
  assign bus.vrf_wr_elem_cnt_o = wrCnt_q;
  assign bus.wr_ack_o          = wrAccept ? (NREQ'(1) << wrWin_q) : '0;
  assign bus.wr_done_o         = wrLast ? (NREQ'(1) << wrWin_q) : '0;
  assign bus.vrf_wdata_o       = (wrState_q == W_DATA) ?
                                 bus.wdata_i[int'(wrWin_q)*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_vrf_port_sched.sv
// Directed bench for vrf_port_sched with default geometry
// (32-bit data, 32 registers, 4 lanes, 2 requesters). The bench drives the
// requesters and plays the VRF, asserting vrf_rd_op_ready_i itself.
module tb_vrf_port_sched;

  logic clk_i = 1'b0;
  logic rst_i;
  int   nAsserts;
  int   nFails;
  int   enCount;

  vrf_port_sched_if bus ();

  vrf_port_sched dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outCtrl();
    return {bus.rd_done_o, bus.rd_elem_valid_o, bus.wr_ack_o, bus.wr_done_o,
            bus.vrf_rd_req_o, bus.vrf_is_c_used_o, bus.vrf_a_addr_o, bus.vrf_b_addr_o,
            bus.vrf_c_addr_o, bus.vrf_rd_elem_cnt_o, bus.vrf_wr_req_o, bus.vrf_wr_en_o,
            bus.vrf_wr_ready_o, bus.vrf_wr_addr_o, bus.vrf_wr_elem_cnt_o};
  endfunction

  task automatic clearInputs();
    bus.rd_valid_i        = '0;
    bus.rd_a_addr_i       = '0;
    bus.rd_b_addr_i       = '0;
    bus.rd_c_addr_i       = '0;
    bus.rd_use_c_i        = '0;
    bus.wr_valid_i        = '0;
    bus.wr_addr_i         = '0;
    bus.wdata_i           = '0;
    bus.vrf_rd_op_ready_i = 1'b0;
  endtask

  task automatic applyReset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic readTxn(input int expIdx, input logic [4:0] expA, input logic [4:0] expC,
                         input logic useC);
    int guard;
    logic [1:0] oh;
    guard = 0;
    oh = 2'b01 << expIdx;
    while (bus.vrf_rd_req_o !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput("rd_req_issued", bus.vrf_rd_req_o, 1);
    checkOutput("rd_a_addr", bus.vrf_a_addr_o, expA);
    checkOutput("rd_is_c_used", bus.vrf_is_c_used_o, useC);
    if (useC) checkOutput("rd_c_addr", bus.vrf_c_addr_o, expC);
    tick();
    checkOutput("rd_done_early", bus.rd_done_o, 0);
    if (useC) tick();
    tick();
    bus.vrf_rd_op_ready_i = 1'b1;
    #1;
    checkOutput("rd_done_winner", bus.rd_done_o, oh);
    tick();
    bus.vrf_rd_op_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput("rd_stream_cnt", bus.vrf_rd_elem_cnt_o, k);
      checkOutput("rd_stream_valid", bus.rd_elem_valid_o, oh);
      tick();
    end
  endtask

  initial begin
    nAsserts = 0;
    nFails   = 0;
    enCount  = 0;
    clearInputs();
    applyReset();
    rst_i = 1'b1;
    tick();
    checkOutput("reset_ctrl", outCtrl(), 0);
    checkOutput("reset_wdata", bus.vrf_wdata_o, 0);
    rst_i = 1'b0;

    // Single 2-operand read from requester 1: A=3, B=7.
    bus.rd_valid_i  = 2'b10;
    bus.rd_a_addr_i = {5'd3, 5'd0};
    bus.rd_b_addr_i = {5'd7, 5'd0};
    bus.rd_c_addr_i = {5'd9, 5'd0};
    #1;
    checkOutput("t1_no_req_yet", bus.vrf_rd_req_o, 0);
    tick();
    checkOutput("t1_req", bus.vrf_rd_req_o, 1);
    checkOutput("t1_a", bus.vrf_a_addr_o, 3);
    checkOutput("t1_b", bus.vrf_b_addr_o, 7);
    checkOutput("t1_is_c", bus.vrf_is_c_used_o, 0);
    tick();
    checkOutput("t1_req_one_cycle", bus.vrf_rd_req_o, 0);
    checkOutput("t1_done_early", bus.rd_done_o, 0);
    tick();
    bus.vrf_rd_op_ready_i = 1'b1;
    #1;
    checkOutput("t1_done", bus.rd_done_o, 2'b10);
    tick();
    bus.vrf_rd_op_ready_i = 1'b0;
    bus.rd_valid_i        = 2'b00;
    for (int k = 0; k < 4; k++) begin
      checkOutput("t1_cnt", bus.vrf_rd_elem_cnt_o, k);
      checkOutput("t1_elem_valid", bus.rd_elem_valid_o, 2'b10);
      tick();
    end
    checkOutput("t1_stream_end", bus.rd_elem_valid_o, 0);

    // 3-operand read from requester 0.
    bus.rd_valid_i  = 2'b01;
    bus.rd_a_addr_i = {5'd0, 5'd10};
    bus.rd_b_addr_i = {5'd0, 5'd11};
    bus.rd_c_addr_i = {5'd0, 5'd12};
    bus.rd_use_c_i  = 2'b01;
    readTxn(0, 5'd10, 5'd12, 1'b1);
    clearInputs();

    // Both requesters reading continuously from reset: grants 0,1,0,1.
    applyReset();
    bus.rd_valid_i  = 2'b11;
    bus.rd_a_addr_i = {5'd2, 5'd1};
    readTxn(0, 5'd1, 5'd0, 1'b0);
    readTxn(1, 5'd2, 5'd0, 1'b0);
    readTxn(0, 5'd1, 5'd0, 1'b0);
    readTxn(1, 5'd2, 5'd0, 1'b0);
    clearInputs();

    // Write burst from requester 0 to v9 with a two-cycle stall after element 1.
    bus.wr_valid_i = 2'b01;
    bus.wr_addr_i  = {5'd0, 5'd9};
    bus.wdata_i    = {32'h0, 32'hA5A5_0001};
    #1;
    checkOutput("w_no_req_yet", bus.vrf_wr_req_o, 0);
    tick();
    checkOutput("w_req", bus.vrf_wr_req_o, 1);
    checkOutput("w_req_no_en", bus.vrf_wr_en_o, 0);
    checkOutput("w_addr", bus.vrf_wr_addr_o, 9);
    enCount += int'(bus.vrf_wr_en_o);
    tick();
    checkOutput("w_e0_en", bus.vrf_wr_en_o, 1);
    checkOutput("w_e0_ack", bus.wr_ack_o, 2'b01);
    checkOutput("w_e0_cnt", bus.vrf_wr_elem_cnt_o, 0);
    checkOutput("w_e0_wdata", bus.vrf_wdata_o, 32'hA5A5_0001);
    enCount += int'(bus.vrf_wr_en_o);
    tick();
    checkOutput("w_e1_cnt", bus.vrf_wr_elem_cnt_o, 1);
    enCount += int'(bus.vrf_wr_en_o);
    tick();
    bus.wr_valid_i = 2'b00;
    #1;
    checkOutput("w_stall1_en", bus.vrf_wr_en_o, 0);
    checkOutput("w_stall1_ack", bus.wr_ack_o, 0);
    checkOutput("w_stall1_cnt", bus.vrf_wr_elem_cnt_o, 2);
    enCount += int'(bus.vrf_wr_en_o);
    tick();
    checkOutput("w_stall2_cnt", bus.vrf_wr_elem_cnt_o, 2);
    enCount += int'(bus.vrf_wr_en_o);
    tick();
    bus.wr_valid_i = 2'b01;
    #1;
    checkOutput("w_e2_cnt", bus.vrf_wr_elem_cnt_o, 2);
    checkOutput("w_e2_no_done", bus.wr_done_o, 0);
    enCount += int'(bus.vrf_wr_en_o);
    tick();
    checkOutput("w_e3_cnt", bus.vrf_wr_elem_cnt_o, 3);
    checkOutput("w_e3_done", bus.wr_done_o, 2'b01);
    checkOutput("w_e3_ready", bus.vrf_wr_ready_o, 1);
    enCount += int'(bus.vrf_wr_en_o);
    checkOutput("w_en_pulses", enCount, 4);
    tick();
    bus.wr_valid_i = 2'b00;
    #1;
    checkOutput("w_idle_ctrl", {bus.vrf_wr_req_o, bus.vrf_wr_en_o, bus.vrf_wr_elem_cnt_o}, 0);
    clearInputs();

    // Simultaneous read (requester 0) and write (requester 1).
    bus.rd_valid_i  = 2'b01;
    bus.rd_a_addr_i = {5'd0, 5'd4};
    bus.rd_b_addr_i = {5'd0, 5'd6};
    bus.wr_valid_i  = 2'b10;
    bus.wr_addr_i   = {5'd12, 5'd0};
    bus.wdata_i     = {32'h5555_AAAA, 32'h1111_1111};
    tick();
    checkOutput("s_rd_req", bus.vrf_rd_req_o, 1);
    checkOutput("s_rd_a", bus.vrf_a_addr_o, 4);
    checkOutput("s_wr_req", bus.vrf_wr_req_o, 1);
    tick();
    checkOutput("s_wr_ack", bus.wr_ack_o, 2'b10);
    checkOutput("s_wdata", bus.vrf_wdata_o, 32'h5555_AAAA);
    checkOutput("s_wr_addr", bus.vrf_wr_addr_o, 12);
    tick();
    bus.vrf_rd_op_ready_i = 1'b1;
    #1;
    checkOutput("s_rd_done", bus.rd_done_o, 2'b01);
    checkOutput("s_wr_cnt1", bus.vrf_wr_elem_cnt_o, 1);
    tick();
    bus.vrf_rd_op_ready_i = 1'b0;
    bus.rd_valid_i        = 2'b00;
    #1;
    checkOutput("s_rd_elem", bus.rd_elem_valid_o, 2'b01);
    checkOutput("s_rd_cnt0", bus.vrf_rd_elem_cnt_o, 0);
    checkOutput("s_wr_cnt2", bus.vrf_wr_elem_cnt_o, 2);
    tick();
    checkOutput("s_wr_done", bus.wr_done_o, 2'b10);
    checkOutput("s_rd_cnt1", bus.vrf_rd_elem_cnt_o, 1);
    tick();
    bus.wr_valid_i = 2'b00;
    #1;
    checkOutput("s_wr_idle", bus.vrf_wr_en_o, 0);
    checkOutput("s_rd_cnt2", bus.vrf_rd_elem_cnt_o, 2);
    tick();
    checkOutput("s_rd_cnt3", bus.vrf_rd_elem_cnt_o, 3);
    tick();
    checkOutput("s_rd_end", bus.rd_elem_valid_o, 0);
    clearInputs();

    // Read of v5 (operand B) from requester 1 while requester 0 writes v5.
    bus.wr_valid_i = 2'b01;
    bus.wr_addr_i  = {5'd0, 5'd5};
    bus.wdata_i    = {32'h0, 32'h0000_0055};
    tick();
    checkOutput("raw_wr_req", bus.vrf_wr_req_o, 1);
    bus.rd_valid_i  = 2'b10;
    bus.rd_a_addr_i = {5'd1, 5'd0};
    bus.rd_b_addr_i = {5'd5, 5'd0};
    tick();
`ifdef VRF_SCHED_RAW_CHECK_EN
    checkOutput("raw_rd_held", bus.vrf_rd_req_o, 0);
`else
    checkOutput("raw_rd_immediate", bus.vrf_rd_req_o, 1);
`endif
    tick();
    tick();
`ifndef VRF_SCHED_RAW_CHECK_EN
    bus.vrf_rd_op_ready_i = 1'b1;
    #1;
    checkOutput("raw_rd_done", bus.rd_done_o, 2'b10);
`endif
    tick();
`ifndef VRF_SCHED_RAW_CHECK_EN
    bus.vrf_rd_op_ready_i = 1'b0;
    bus.rd_valid_i        = 2'b00;
`endif
    #1;
    checkOutput("raw_wr_done", bus.wr_done_o, 2'b01);
    tick();
    bus.wr_valid_i = 2'b00;
`ifdef VRF_SCHED_RAW_CHECK_EN
    checkOutput("raw_rd_still_held", bus.vrf_rd_req_o, 0);
    tick();
    checkOutput("raw_rd_released", bus.vrf_rd_req_o, 1);
    checkOutput("raw_rd_b", bus.vrf_b_addr_o, 5);
`endif
    clearInputs();
    applyReset();

    // Reset in the middle of a write burst (count 2) with a read in flight.
    bus.wr_valid_i  = 2'b01;
    bus.wr_addr_i   = {5'd0, 5'd7};
    bus.wdata_i     = {32'h0, 32'hCAFE_0000};
    bus.rd_valid_i  = 2'b01;
    bus.rd_a_addr_i = {5'd0, 5'd3};
    tick();
    tick();
    tick();
    tick();
    checkOutput("rst_pre_cnt", bus.vrf_wr_elem_cnt_o, 2);
    rst_i = 1'b1;
    tick();
    checkOutput("rst_mid_ctrl", outCtrl(), 0);
    checkOutput("rst_mid_wdata", bus.vrf_wdata_o, 0);
    rst_i = 1'b0;
    tick();
    checkOutput("rst_restart_req", bus.vrf_wr_req_o, 1);
    tick();
    checkOutput("rst_restart_cnt", bus.vrf_wr_elem_cnt_o, 0);
    checkOutput("rst_restart_en", bus.vrf_wr_en_o, 1);
    clearInputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
